mem_sync_sp_master: RTL and testbench
=====================================

// Module: mem_sync_sp_master
// PURPOSE
//  Initiator for the single-port synchronous memory (1-cycle read latency, write-first, per-byte write enables).
//  Converts one load/store request per transaction (valid/ready) into a memory-port access.
//  Generates byte enables and lane-shifted write data, then extracts and sign/zero-extends load data.
//  Returns a registered response (valid/ready). Sits between the core LSU / fetch path and the code/data memory.
// PARAMETERS
//  ADDR_WIDTH      32               byte address width of the request
//  DATA_WIDTH      64               memory word width; legal values 32 or 64
//  DATA_BYTES      DATA_WIDTH/8     byte lanes per memory word
//  MEM_ADDR_WIDTH  11               memory word-address width (clog2 of memory depth)
// PORTS
//  clk             in   1               clock; all state updates on rising edge
//  rst_n           in   1               asynchronous active-low reset
//  i_req_valid     in   1               request valid
//  o_req_ready     out  1               request accepted when valid & ready
//  i_req_addr      in   ADDR_WIDTH      byte address
//  i_req_we        in   1               1=store, 0=load
//  i_req_size      in   2               0=byte 1=half 2=word 3=dword (dword only if DATA_WIDTH=64)
//  i_req_unsigned  in   1               load zero-extend when 1, sign-extend when 0
//  i_req_wdata     in   DATA_WIDTH      store data, right-aligned (bit 0 = LSB of operand)
//  o_rsp_valid     out  1               response valid; held until accepted
//  i_rsp_ready     in   1               response accepted when valid & ready
//  o_rsp_rdata     out  DATA_WIDTH      load result, extended to DATA_WIDTH; 0 for stores/errors
//  o_rsp_err       out  1               1 = misaligned or illegal-size request, no memory access made
//  o_mem_addr      out  MEM_ADDR_WIDTH  word address = i_req_addr[log2(DATA_BYTES) +: MEM_ADDR_WIDTH]
//  o_mem_wdata     out  DATA_WIDTH      store data shifted to lane offset
//  o_mem_wen       out  DATA_BYTES      per-byte write enable
//  i_mem_rdata     in   DATA_WIDTH      memory read data, valid one cycle after address is sampled
// BEHAVIOUR
//  Reset (async): state=IDLE; o_req_ready=1; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0;
//   o_mem_addr=0, o_mem_wdata=0, o_mem_wen=0. All outputs are registered.
//  FSM IDLE -> MEM -> CAPT -> RESP -> IDLE; o_req_ready=1 only in IDLE (one outstanding transaction).
//  IDLE: on accept, register offset=addr[log2(DATA_BYTES)-1:0], size, unsigned flag, and o_mem_addr.
//   Legal aligned store: o_mem_wen = ((1<<(1<<size))-1) << offset, o_mem_wdata = wdata << (8*offset).
//   Legal load: o_mem_wen=0. Go to MEM.
//   Misaligned (offset % (1<<size) != 0) or size=3 with DATA_WIDTH=32: no mem outputs change;
//    o_rsp_err=1, o_rsp_rdata=0, o_rsp_valid=1 at the same edge; go to RESP.
//  MEM: memory samples addr/wen at end of cycle; o_mem_wen cleared at that edge (wen high exactly 1 cycle).
//  CAPT: i_mem_rdata valid (write-first: a store reads back new data); o_mem_addr held.
//   Load: o_rsp_rdata = (i_mem_rdata >> 8*offset) truncated to 8<<size bits,
//    then sign-extended (unsigned=0) or zero-extended (unsigned=1) to DATA_WIDTH.
//   Store: o_rsp_rdata=0. o_rsp_err=0; o_rsp_valid=1 at this edge; go to RESP.
//  RESP: response outputs stable while o_rsp_valid & !i_rsp_ready.
//   On i_rsp_ready: o_rsp_valid=0, o_rsp_err=0, go to IDLE. A new request is accepted no earlier than next cycle.
//  Latency: accept edge t -> o_rsp_valid high after edge t+2 (legal) or t (error, visible after accept edge).
//  Request inputs are ignored outside IDLE; valid may stay high without being re-accepted.
//  Address bits above the memory word-address field are ignored (wrap modulo memory size).
//  Dword load with DATA_WIDTH=64: no extension needed; full word returned.
//  Reset mid-operation: async clear of o_mem_wen; a store in MEM when rst_n falls does not write.
//   Any pending response is discarded.
// TESTING
//  1. Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately, o_req_ready=1 after release.
//  2. Store byte 0xA5 at addr 0x13 (64b) -> o_mem_addr=2, o_mem_wen=8'h08, o_mem_wdata[31:24]=A5;
//     wen high one cycle; rsp rdata=0, err=0.
//  3. Load signed byte addr 0x13 after test 2 -> o_rsp_rdata=64'hFFFF_FFFF_FFFF_FFA5 two edges after accept;
//     unsigned -> 64'h00000000000000A5.
//  4. Store word 0x8000_0001 at 0x24, load signed half at 0x26 -> 0xFFFF_FFFF_FFFF_8000;
//     load dword 0x20 -> 64'h8000_0001_xxxx_xxxx upper lanes.
//  5. Misaligned half load at 0x11 and word store at 0x22 -> o_rsp_err=1, rdata=0,
//     o_mem_wen never asserted, memory unchanged.
//  6. Backpressure: hold i_rsp_ready=0 for 5 cycles -> rsp stable, o_req_ready=0;
//     rst_n pulse during MEM of a store -> location unchanged on read-back.

Source files
------------

// File: rtl/mem_sync_sp_master.sv
// rtl/mem_sync_sp_master.sv - load/store initiator for a 1-cycle-latency single-port synchronous memory
module mem_sync_sp_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int DATA_BYTES     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic                      i_req_we,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_unsigned,
    input  logic [DATA_WIDTH-1:0]     i_req_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_BYTES-1:0]     o_mem_wen,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);
    localparam int OFF_W = $clog2(DATA_BYTES);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_CAPT, S_RESP} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_req_ready, w_req_ready_nxt;
    logic                      r_rsp_valid, w_rsp_valid_nxt;
    logic                      r_rsp_err, w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_BYTES-1:0]     r_mem_wen, w_mem_wen_nxt;
    logic [OFF_W-1:0]          r_off, w_off_nxt;
    logic [1:0]                r_size, w_size_nxt;
    logic                      r_uns, w_uns_nxt;
    logic                      r_we, w_we_nxt;

    logic [OFF_W-1:0]          w_req_off;
    logic [OFF_W-1:0]          w_align_mask;
    logic [DATA_BYTES-1:0]     w_byte_mask;
    logic                      w_req_err;
    logic [DATA_WIDTH-1:0]     w_shifted;
    logic [DATA_WIDTH-1:0]     w_keep;
    logic [IDX_W-1:0]          w_sign_idx;
    logic [DATA_WIDTH-1:0]     w_load;
    logic                      w_unused_addr_bits;

    assign w_req_off          = i_req_addr[OFF_W-1:0];
    assign w_unused_addr_bits = ^i_req_addr[ADDR_WIDTH-1:OFF_W+MEM_ADDR_WIDTH];

    // Request decode: alignment mask, lane mask and the illegal-size case.
    always_comb begin
        w_align_mask = '0;
        w_byte_mask  = '0;
        for (int i = 0; i < OFF_W; i++) begin
            w_align_mask[i] = 32'(i) < 32'(i_req_size);
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_byte_mask[i] = 32'(i) < (32'd1 << i_req_size);
        end
        w_req_err = ((32'd8 << i_req_size) > 32'(DATA_WIDTH)) || (|(w_req_off & w_align_mask));
    end

    // Load extraction: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        w_shifted  = i_mem_rdata >> {r_off, 3'b000};
        w_keep     = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_keep[i] = 32'(i) < (32'd8 << r_size);
        end
        w_sign_idx = IDX_W'((32'd8 << r_size) - 32'd1);
        w_load     = w_shifted & w_keep;
        if (!r_uns && w_shifted[w_sign_idx]) begin
            w_load = w_load | ~w_keep;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wen_nxt   = r_mem_wen;
        w_off_nxt       = r_off;
        w_size_nxt      = r_size;
        w_uns_nxt       = r_uns;
        w_we_nxt        = r_we;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    if (w_req_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                        w_state_nxt     = S_RESP;
                    end else begin
                        w_off_nxt      = w_req_off;
                        w_size_nxt     = i_req_size;
                        w_uns_nxt      = i_req_unsigned;
                        w_we_nxt       = i_req_we;
                        w_mem_addr_nxt = i_req_addr[OFF_W +: MEM_ADDR_WIDTH];
                        if (i_req_we) begin
                            w_mem_wen_nxt   = w_byte_mask << w_req_off;
                            w_mem_wdata_nxt = i_req_wdata << {w_req_off, 3'b000};
                        end else begin
                            w_mem_wen_nxt = '0;
                        end
                        w_state_nxt = S_MEM;
                    end
                end
            end
            S_MEM: begin
                w_mem_wen_nxt = '0;
                w_state_nxt   = S_CAPT;
            end
            S_CAPT: begin
                w_rsp_rdata_nxt = r_we ? '0 : w_load;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wen   <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
            r_off       <= w_off_nxt;
            r_size      <= w_size_nxt;
            r_uns       <= w_uns_nxt;
            r_we        <= w_we_nxt;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wen   = r_mem_wen;
endmodule

// File: tb/tb_mem_sync_sp_master.sv
// tb/tb_mem_sync_sp_master.sv - bench for mem_sync_sp_master against a byte-array memory model
module tb_mem_sync_sp_master;
    localparam int NW = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_unsigned = 1'b0;
    logic [63:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [10:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wen;
    logic [63:0] i_mem_rdata = '0;

    int total = 0;
    int bad = 0;

    mem_sync_sp_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_ADDR_WIDTH(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_we(i_req_we), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wen(o_mem_wen),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, write-first, one cycle read latency.
    logic [63:0] mem [NW];
    always @(posedge clk) begin
        logic [63:0] w;
        w = mem[o_mem_addr];
        for (int b = 0; b < 8; b++) begin
            if (o_mem_wen[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
        end
        mem[o_mem_addr] = w;
        i_mem_rdata <= w;
    end

    // Reference: flat byte-addressed image of the memory.
    logic [7:0] gmem [NW*8];

    function automatic logic [63:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        int nb = 1 << sz;
        int base = int'(a & 32'h3FFF);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = gmem[base + i];
        if (!u && nb < 8 && v[8*nb-1]) begin
            for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata,
                           output logic [63:0] rd, output logic er);
        int nb, off, lat, wcnt;
        logic experr;
        logic [63:0] exp, dseen;
        logic [15:0] m;
        logic [7:0] wseen;
        logic [10:0] aseen;
        nb = 1 << size;
        off = int'(addr % 8);
        experr = (addr % nb) != 0;
        exp = (experr || we) ? 64'd0 : model_load(addr, size, uns);
        wcnt = 0; wseen = '0; aseen = '0; dseen = '0;
        check("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
        i_req_size = size; i_req_unsigned = uns; i_req_wdata = wdata;
        @(posedge clk); @(negedge clk);
        i_req_valid = 1'b0;
        lat = 0;
        while (!o_rsp_valid && lat < 8) begin
            if (o_mem_wen != 0) begin
                wcnt++; wseen = o_mem_wen; aseen = o_mem_addr; dseen = o_mem_wdata;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), experr ? 64'd0 : 64'd2);
        check("rsp_err", {63'd0, o_rsp_err}, {63'd0, experr});
        check("rsp_rdata", o_rsp_rdata, exp);
        if (we && !experr) begin
            m = ((16'd1 << nb) - 16'd1) << off;
            check("wen_cycles", 64'(wcnt), 64'd1);
            check("mem_wen", {56'd0, wseen}, {56'd0, m[7:0]});
            check("mem_addr", {53'd0, aseen}, {53'd0, addr[13:3]});
            check("mem_wdata", dseen, wdata << (8*off));
            for (int i = 0; i < nb; i++) gmem[int'(addr & 32'h3FFF) + i] = wdata[8*i +: 8];
        end else begin
            check("wen_never", 64'(wcnt), 64'd0);
        end
        rd = o_rsp_rdata; er = o_rsp_err;
        @(posedge clk); @(negedge clk);
        check("rsp_retired", {63'd0, o_rsp_valid}, 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [1:0]  chk;   // 0: model only, 1: full constant, 2: upper half constant
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [1:0] s, input logic u,
                                input logic [63:0] wd, input logic [1:0] c, input logic [63:0] e, input logic ee);
        vec_t v;
        v.we = we; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
        v.chk = c; v.exp_rdata = e; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [63:0] rd, v;
        logic er;

        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic [63:0] rd, v, held;
        logic er;

        for (int w = 0; w < NW; w++) begin
            v = {$urandom, $urandom};
            mem[w] = v;
            for (int b = 0; b < 8; b++) gmem[w*8 + b] = v[8*b +: 8];
        end

        // Reset asserted mid-cycle clears outputs immediately.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        check("rst_rsp_err", {63'd0, o_rsp_err}, 64'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 64'd0);
        check("rst_mem_wen", {56'd0, o_mem_wen}, 64'd0);
        check("rst_mem_addr", {53'd0, o_mem_addr}, 64'd0);
        check("rst_mem_wdata", o_mem_wdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("rst_req_ready", {63'd0, o_req_ready}, 64'd1);

        vecs.push_back(mk(1, 32'h13, 0, 0, 64'hA5, 1, 64'd0, 0));
        vecs.push_back(mk(0, 32'h13, 0, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFA5, 0));
        vecs.push_back(mk(0, 32'h13, 0, 1, 64'd0, 1, 64'h0000_0000_0000_00A5, 0));
        vecs.push_back(mk(1, 32'h24, 2, 0, 64'h8000_0001, 1, 64'd0, 0));
        vecs.push_back(mk(0, 32'h26, 1, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_8000, 0));
        vecs.push_back(mk(0, 32'h20, 3, 0, 64'd0, 2, 64'h8000_0001_0000_0000, 0));
        vecs.push_back(mk(0, 32'h11, 1, 0, 64'd0, 1, 64'd0, 1));
        vecs.push_back(mk(1, 32'h22, 2, 0, 64'hDEAD_BEEF, 1, 64'd0, 1));
        vecs.push_back(mk(0, 32'h10, 3, 0, 64'd0, 0, 64'd0, 0));
        vecs.push_back(mk(0, 32'h20, 3, 0, 64'd0, 2, 64'h8000_0001_0000_0000, 0));
        vecs.push_back(mk(1, 32'h38, 3, 0, 64'h0123_4567_89AB_CDEF, 1, 64'd0, 0));
        vecs.push_back(mk(0, 32'h3C, 2, 1, 64'd0, 1, 64'h0000_0000_0123_4567, 0));
        vecs.push_back(mk(0, 32'h3E, 1, 0, 64'd0, 1, 64'h0000_0000_0000_0123, 0));
        vecs.push_back(mk(0, 32'h3F, 0, 0, 64'd0, 1, 64'h0000_0000_0000_0001, 0));
        vecs.push_back(mk(0, 32'h4038, 3, 1, 64'd0, 1, 64'h0123_4567_89AB_CDEF, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            run_txn(vecs[k].we, vecs[k].addr, vecs[k].size, vecs[k].uns, vecs[k].wdata, rd, er);
            if (vecs[k].chk == 2'd1) check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            if (vecs[k].chk == 2'd2) check($sformatf("vec%0d_rdata_hi", k), {rd[63:32], 32'd0}, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), {63'd0, er}, {63'd0, vecs[k].exp_err});
        end

        // Backpressure: response held stable, no new request accepted.
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h38; i_req_size = 2'd3; i_req_unsigned = 1'b1;
        @(posedge clk); @(negedge clk);
        i_req_valid = 1'b0;
        for (int c = 0; c < 8 && !o_rsp_valid; c++) begin
            @(posedge clk); @(negedge clk);
        end
        check("bp_valid", {63'd0, o_rsp_valid}, 64'd1);
        held = o_rsp_rdata;
        check("bp_rdata", held, 64'h0123_4567_89AB_CDEF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check("bp_hold_valid", {63'd0, o_rsp_valid}, 64'd1);
            check("bp_hold_rdata", o_rsp_rdata, 64'h0123_4567_89AB_CDEF);
            check("bp_req_ready", {63'd0, o_req_ready}, 64'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_release_valid", {63'd0, o_rsp_valid}, 64'd0);
        check("bp_release_ready", {63'd0, o_req_ready}, 64'd1);

        // Reset pulse during MEM of a store: the write must not happen.
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h40; i_req_size = 2'd3;
        i_req_wdata = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); @(negedge clk);
        i_req_valid = 1'b0;
        check("rstmem_wen_pre", {56'd0, o_mem_wen}, 64'hFF);
        rst_n = 1'b0;
        #1;
        check("rstmem_wen_clr", {56'd0, o_mem_wen}, 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("rstmem_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
        run_txn(1'b0, 32'h40, 2'd3, 1'b1, 64'd0, rd, er);

        // Randomized traffic against the byte-image model.
        for (int k = 0; k < 200; k++) begin
            run_txn(1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 127)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
